// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
//   mem_err_t   : error code returned with every result
//   lsu_state_t : transaction state
//   dmem_req_t  : registered data-memory request payload
//   SIZE_*      : load/store size encodings from the decode stage
package load_store_unit_pkg;

  localparam int unsigned OPERAND_WIDTH = 32;
  localparam int unsigned BE_WIDTH      = OPERAND_WIDTH / 8;
  localparam int unsigned SIZE_WIDTH    = 3;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'b00,
    ERR_MISALIGNED  = 2'b01,
    ERR_BUS_TIMEOUT = 2'b10,
    ERR_ILLEGAL     = 2'b11
  } mem_err_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic                     we;
    logic [OPERAND_WIDTH-1:0] addr;
    logic [BE_WIDTH-1:0]      be;
    logic [OPERAND_WIDTH-1:0] wdata;
  } dmem_req_t;

  localparam logic [SIZE_WIDTH-1:0] SIZE_LB  = 3'b000;
  localparam logic [SIZE_WIDTH-1:0] SIZE_LH  = 3'b001;
  localparam logic [SIZE_WIDTH-1:0] SIZE_LW  = 3'b010;
  localparam logic [SIZE_WIDTH-1:0] SIZE_LBU = 3'b100;
  localparam logic [SIZE_WIDTH-1:0] SIZE_LHU = 3'b101;

  localparam logic [SIZE_WIDTH-1:0] SIZE_SB  = 3'b000;
  localparam logic [SIZE_WIDTH-1:0] SIZE_SH  = 3'b001;
  localparam logic [SIZE_WIDTH-1:0] SIZE_SW  = 3'b010;

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction and sign/zero extension.
//   rdata  : raw data word from memory
//   offset : byte offset within the word (addr[1:0])
//   size   : load size encoding (LB/LH/LW/LBU/LHU)
//   data_c : extended result
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [OPERAND_WIDTH-1:0] rdata,
  input  logic [1:0]               offset,
  input  logic [SIZE_WIDTH-1:0]    size,
  output logic [OPERAND_WIDTH-1:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Pick the addressed lane, then extend according to the size.
  always_comb begin
    byte_c = rdata[7:0];
    case (offset)
      2'd1:    byte_c = rdata[15:8];
      2'd2:    byte_c = rdata[23:16];
      2'd3:    byte_c = rdata[31:24];
      default: byte_c = rdata[7:0];
    endcase
    half_c = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SIZE_LB:  data_c = {{24{byte_c[7]}}, byte_c};
      SIZE_LBU: data_c = {24'b0, byte_c};
      SIZE_LH:  data_c = {{16{half_c[15]}}, half_c};
      SIZE_LHU: data_c = {16'b0, half_c};
      default:  data_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory.
//   in_*      : instruction from execute (valid/ready), address/data/control
//   dmem_*    : registered request/grant data-memory bus
//   out_*     : one result per instruction to writeback (valid/ready)
// Stalls upstream (in_ready low) from accept until the result is taken.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] alu_result,
  input  logic [OPERAND_WIDTH-1:0] write_data,
  input  logic                     ctrl_mem_read,
  input  logic                     ctrl_mem_write,
  input  logic [SIZE_WIDTH-1:0]    ctrl_load_size,
  input  logic [SIZE_WIDTH-1:0]    ctrl_store_size,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [OPERAND_WIDTH-1:0] dmem_addr,
  output logic [BE_WIDTH-1:0]      dmem_be,
  output logic [OPERAND_WIDTH-1:0] dmem_wdata,
  input  logic                     dmem_gnt,
  input  logic                     dmem_rvalid,
  input  logic [OPERAND_WIDTH-1:0] dmem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] out_data,
  output logic [1:0]               out_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t               state;
  logic [CNT_W-1:0]         cnt;
  dmem_req_t                bus;
  logic                     req_q;
  logic                     ready_q;
  logic                     valid_q;
  logic [OPERAND_WIDTH-1:0] data_q;
  mem_err_t                 err_q;
  logic                     load_q;
  logic [1:0]               off_q;
  logic [SIZE_WIDTH-1:0]    lsize_q;

  logic                     illegal_c;
  logic                     misaligned_c;
  logic [BE_WIDTH-1:0]      be_c;
  logic [OPERAND_WIDTH-1:0] wdata_c;
  logic [OPERAND_WIDTH-1:0] load_data_c;
  logic                     timeout_c;

  // Last cycle the transaction may still complete; the counter would reach the limit at this edge.
  assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Size legality and natural alignment of the incoming instruction.
  always_comb begin
    illegal_c    = 1'b0;
    misaligned_c = 1'b0;
    if (ctrl_mem_read && ctrl_mem_write) begin
      illegal_c = 1'b1;
    end else if (ctrl_mem_read) begin
      case (ctrl_load_size)
        SIZE_LB, SIZE_LBU: misaligned_c = 1'b0;
        SIZE_LH, SIZE_LHU: misaligned_c = alu_result[0];
        SIZE_LW:           misaligned_c = |alu_result[1:0];
        default:           illegal_c    = 1'b1;
      endcase
    end else if (ctrl_mem_write) begin
      case (ctrl_store_size)
        SIZE_SB: misaligned_c = 1'b0;
        SIZE_SH: misaligned_c = alu_result[0];
        SIZE_SW: misaligned_c = |alu_result[1:0];
        default: illegal_c    = 1'b1;
      endcase
    end
  end

  // Store byte enables and lane-replicated data; loads read the whole word.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = '0;
    if (ctrl_mem_write) begin
      case (ctrl_store_size)
        SIZE_SB: begin
          be_c    = 4'b0001 << alu_result[1:0];
          wdata_c = {4{write_data[7:0]}};
        end
        SIZE_SH: begin
          be_c    = alu_result[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{write_data[15:0]}};
        end
        default: wdata_c = write_data;
      endcase
    end
  end

  lsu_load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (off_q),
    .size   (lsize_q),
    .data_c (load_data_c)
  );

  // Transaction FSM with registered bus and writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bus     <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= ERR_NONE;
      load_q  <= 1'b0;
      off_q   <= '0;
      lsize_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ready_q <= 1'b0;
            load_q  <= ctrl_mem_read;
            off_q   <= alu_result[1:0];
            lsize_q <= ctrl_load_size;
            if (!ctrl_mem_read && !ctrl_mem_write) begin
              state   <= RESP;
              valid_q <= 1'b1;
              data_q  <= alu_result;
              err_q   <= ERR_NONE;
            end else if (illegal_c) begin
              state   <= RESP;
              valid_q <= 1'b1;
              data_q  <= '0;
              err_q   <= ERR_ILLEGAL;
            end else if (misaligned_c) begin
              state   <= RESP;
              valid_q <= 1'b1;
              data_q  <= '0;
              err_q   <= ERR_MISALIGNED;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              req_q     <= 1'b1;
              bus.we    <= ctrl_mem_write;
              bus.addr  <= {alu_result[OPERAND_WIDTH-1:2], 2'b00};
              bus.be    <= be_c;
              bus.wdata <= wdata_c;
            end
          end
        end
        REQ: begin
          if (dmem_gnt && (!load_q || dmem_rvalid)) begin
            state   <= RESP;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            data_q  <= load_q ? load_data_c : '0;
            err_q   <= ERR_NONE;
          end else if (timeout_c) begin
            state   <= RESP;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            data_q  <= '0;
            err_q   <= ERR_BUS_TIMEOUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (dmem_gnt) begin
              state <= WAIT;
              req_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state   <= RESP;
            valid_q <= 1'b1;
            data_q  <= load_data_c;
            err_q   <= ERR_NONE;
          end else if (timeout_c) begin
            state   <= RESP;
            valid_q <= 1'b1;
            data_q  <= '0;
            err_q   <= ERR_BUS_TIMEOUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign dmem_req   = req_q;
  assign dmem_we    = bus.we;
  assign dmem_addr  = bus.addr;
  assign dmem_be    = bus.be;
  assign dmem_wdata = bus.wdata;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues instructions and
// pushes expected results from a byte-level model; a bus responder serves
// dmem requests; a monitor pops and compares every delivered result.
module tb_load_store_unit;

  localparam int TO = 16;
  localparam logic [1:0] E_NONE = 2'b00, E_MIS = 2'b01, E_TO = 2'b10, E_ILL = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] alu_result = '0, write_data = '0;
  logic        ctrl_mem_read = 1'b0, ctrl_mem_write = 1'b0;
  logic [2:0]  ctrl_load_size = '0, ctrl_store_size = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .write_data(write_data),
    .ctrl_mem_read(ctrl_mem_read), .ctrl_mem_write(ctrl_mem_write),
    .ctrl_load_size(ctrl_load_size), .ctrl_store_size(ctrl_store_size),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err)
  );

  typedef struct {
    logic rd, wr;
    logic [2:0] lsize, ssize;
    logic [31:0] addr, wd, rdata;
    int gdly, rdly;  // grant delay, rvalid delay after grant (<0: never)
  } op_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata, rdata;
    int gdly, rdly;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   total = 0, bad = 0;
  int   ready_mode = 1;  // 0 random, 1 high, 2 low
  bit   noise = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic op_t mk(input logic rd, input logic wr, input logic [2:0] ls,
                             input logic [2:0] ss, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdat, input int g, input int r);
    op_t o;
    o.rd = rd; o.wr = wr; o.lsize = ls; o.ssize = ss; o.addr = a; o.wd = wd;
    o.rdata = rdat; o.gdly = g; o.rdly = r;
    return o;
  endfunction

  // Access width in bytes; 0 means the encoding is illegal.
  function automatic int nbytes_of(input op_t o);
    if (o.rd && o.wr) return 0;
    if (o.rd) begin
      case (o.lsize)
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    end
    case (o.ssize)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  // Reference model: expected result plus expected bus transaction.
  task automatic issue(input op_t o);
    exp_t e;
    bus_t b;
    int n, off, comp, w;
    logic [31:0] mask, val;
    bit has_bus;
    n = nbytes_of(o);
    off = int'(o.addr[1:0]);
    has_bus = 1'b0;
    e.lat = 0;
    e.data = '0;
    e.err = E_NONE;
    if (!o.rd && !o.wr) e.data = o.addr;
    else if (n == 0) e.err = E_ILL;
    else if ((off % n) != 0) e.err = E_MIS;
    else begin
      has_bus = 1'b1;
      b.addr = o.addr & ~32'h3;
      b.we = o.wr;
      b.rdata = o.rdata;
      b.gdly = o.gdly;
      b.rdly = o.rdly;
      b.be = 4'hF;
      b.wdata = '0;
      if (o.wr) begin
        for (int i = 0; i < 4; i++) begin
          b.be[i] = (i >= off) && (i < off + n);
          b.wdata[8*i +: 8] = o.wd[8*(i % n) +: 8];
        end
        comp = o.gdly;
      end else begin
        comp = (o.rdly < 0) ? 1000 : o.gdly + o.rdly;
      end
      mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
      val = (o.rdata >> (8 * off)) & mask;
      if (!o.lsize[2] && n < 4 && val[8*n-1]) val = val | ~mask;
      if (comp > TO - 1) begin
        e.err = E_TO;
        e.lat = TO;
      end else begin
        e.data = o.wr ? 32'h0 : val;
        e.lat = 1 + comp;
      end
    end
    w = 0;
    @(posedge clk); #1;
    while (!in_ready) begin
      if (w++ > 300) begin
        flag("in_ready_wait");
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    alu_result = o.addr;
    write_data = o.wd;
    ctrl_mem_read = o.rd;
    ctrl_mem_write = o.wr;
    ctrl_load_size = o.lsize;
    ctrl_store_size = o.ssize;
    e.acc = cyc + 1;
    exp_q.push_back(e);
    if (has_bus) bus_q.push_back(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_result = $urandom;
    write_data = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 || !in_ready) begin
      if (w++ > 1000) begin
        flag("drain_timeout");
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  // Writeback ready generator.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 2) != 0);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Bus responder: 0 idle, 1 awaiting grant, 2 awaiting rvalid, 3 stray request.
  initial begin
    bus_t cur;
    int phase, gcnt, rcnt;
    phase = 0; gcnt = 0; rcnt = 0;
    cur = '{default: 0};
    forever begin
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata = $urandom;
      if (!rst_n) begin
        phase = 0;
        continue;
      end
      if (noise) begin
        dmem_gnt = 1'b1;
        dmem_rvalid = 1'b1;
        continue;
      end
      if (phase == 2 && dmem_req) phase = 0;
      if (phase == 3 && !dmem_req) phase = 0;
      if (phase == 2) begin
        if (cur.rdly >= 0) begin
          if (rcnt == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata = cur.rdata;
            phase = 0;
          end else rcnt--;
        end
      end else if (phase == 1 && !dmem_req) begin
        phase = 0;
      end else if (phase == 0 && dmem_req) begin
        if (bus_q.size() == 0) begin
          flag("unexpected_dmem_req");
          phase = 3;
        end else begin
          cur = bus_q.pop_front();
          phase = 1;
          gcnt = cur.gdly;
        end
      end
      if (phase == 1) begin
        chk("bus_fields", {dmem_addr, dmem_be, dmem_we, cur.we ? dmem_wdata : 32'h0},
            {cur.addr, cur.be, cur.we, cur.we ? cur.wdata : 32'h0});
        if (gcnt == 0) begin
          dmem_gnt = 1'b1;
          if (cur.we) phase = 0;
          else if (cur.rdly == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata = cur.rdata;
            phase = 0;
          end else begin
            phase = 2;
            rcnt = cur.rdly - 1;
          end
        end else gcnt--;
      end
    end
  end

  // Result monitor: latency on presentation, hold while stalled, value on handshake.
  initial begin
    bit pv, pr;
    logic [31:0] pd;
    logic [1:0] pe;
    exp_t e;
    pv = 1'b0; pr = 1'b0; pd = '0; pe = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (out_valid) begin
        chk("in_ready_in_resp", in_ready, 1'b0);
        if (!pv || pr) begin
          if (exp_q.size() == 0) flag("unexpected_out_valid");
          else chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
        end else begin
          chk("hold_data", out_data, pd);
          chk("hold_err", out_err, pe);
        end
        if (out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_err", out_err, e.err);
        end
      end else if (pv && !pr) begin
        flag("out_valid_dropped");
      end
      pv = out_valid; pr = out_ready; pd = out_data; pe = out_err;
    end
  end

  // Stimulus.
  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, out_valid, out_data, out_err, in_ready},
        {1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b1});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 1;

    issue(mk(0, 1, 0, 2, 32'h10, 32'hDEAD_BEEF, 0, 2, 0));   // SW, gnt after 2
    issue(mk(0, 1, 0, 0, 32'h13, 32'h0000_00A5, 0, 0, 0));   // SB lane 3
    issue(mk(0, 1, 0, 1, 32'h12, 32'h1234_ABCD, 0, 1, 0));   // SH upper half
    issue(mk(1, 0, 0, 0, 32'h21, 0, 32'h0000_8000, 0, 1));   // LB
    issue(mk(1, 0, 4, 0, 32'h21, 0, 32'h0000_8000, 1, 2));   // LBU
    issue(mk(1, 0, 1, 0, 32'h22, 0, 32'h8001_0000, 1, 0));   // LH
    issue(mk(1, 0, 2, 0, 32'h40, 0, 32'h1357_9BDF, 0, 0));   // LW, gnt+rvalid together
    issue(mk(1, 0, 2, 0, 32'h06, 0, 0, 0, 0));               // LW misaligned
    issue(mk(1, 0, 3, 0, 32'h08, 0, 0, 0, 0));               // load size 011
    issue(mk(0, 1, 0, 3, 32'h08, 32'h55, 0, 0, 0));          // store size 011
    issue(mk(1, 1, 2, 2, 32'h08, 32'h55, 0, 0, 0));          // read and write
    issue(mk(0, 0, 0, 0, 32'h1234_5678, 0, 0, 0, 0));        // non-memory op
    issue(mk(0, 1, 0, 2, 32'h80, 32'hA5A5_0F0F, 0, 15, 0));  // grant on the last allowed cycle
    issue(mk(0, 1, 0, 2, 32'h84, 32'h1, 0, 16, 0));          // grant one cycle too late
    issue(mk(1, 0, 2, 0, 32'h90, 0, 32'h1, 0, -1));          // rvalid never returns
    issue(mk(1, 0, 2, 0, 32'h94, 0, 32'h2, 0, 20));          // rvalid after timeout
    repeat (30) @(posedge clk);
    #1;
    drain();

    // Result held while writeback stalls.
    ready_mode = 2;
    issue(mk(0, 0, 0, 0, 32'hCAFE_0001, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, 32'hCAFE_0001);
      chk("stall_err", out_err, E_NONE);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    ready_mode = 1;
    drain();

    // Reset while a request is outstanding.
    issue(mk(1, 0, 2, 0, 32'hA0, 0, 32'h3, 1000, 0));
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_req_drop", {dmem_req, out_valid, in_ready}, {1'b0, 1'b0, 1'b1});
    exp_q.delete();
    bus_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    noise = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_ignores_bus", {out_valid, in_ready, dmem_req}, {1'b0, 1'b1, 1'b0});
    end
    noise = 1'b0;

    // Randomized traffic.
    ready_mode = 0;
    for (int k = 0; k < 300; k++) begin
      op_t o;
      int r, n;
      r = $urandom_range(0, 9);
      o.rd = (r <= 3) || (r == 9);
      o.wr = (r >= 4 && r <= 7) || (r == 9);
      case ($urandom_range(0, 5))
        0: o.lsize = 3'd0;
        1: o.lsize = 3'd1;
        2: o.lsize = 3'd2;
        3: o.lsize = 3'd4;
        4: o.lsize = 3'd5;
        default: o.lsize = 3'($urandom);
      endcase
      o.ssize = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      o.addr = $urandom;
      o.wd = $urandom;
      o.rdata = $urandom;
      n = nbytes_of(o);
      if (n > 1 && $urandom_range(0, 3) != 0) o.addr = o.addr & ~32'(n - 1);
      o.gdly = ($urandom_range(0, 19) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 3);
      o.rdly = $urandom_range(0, 3);
      issue(o);
    end
    ready_mode = 1;
    drain();
    chk("bus_q_empty", bus_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the data memory.
- Turns the ALU-computed address and the rs2/forwarded store data into a registered request/grant bus transaction, with byte enables and lane-replicated store data.
- Extracts and sign/zero-extends load data, and delivers one result per instruction to writeback through a valid/ready handshake.
- Detects misaligned accesses, illegal size encodings and bus timeouts, and stalls upstream while a transaction is outstanding.

Parameters:
- OPERAND_WIDTH, 32, data/address width; comes from the common package, and the block supports only 32.
- TIMEOUT_CYCLES, 16, cycles allowed from request issue to completion before a bus error is reported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  unit can accept; high only in IDLE
- alu_result  in  OPERAND_WIDTH  byte address, or the result for non-memory ops
- write_data  in  OPERAND_WIDTH  store data (rs2, or mem/wb forward)
- ctrl_mem_read  in  1  load instruction
- ctrl_mem_write  in  1  store instruction; read and write both high is treated as illegal
- ctrl_load_size  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ctrl_store_size  in  3  000 SB, 001 SH, 010 SW
- dmem_req  out  1  bus request; held until dmem_gnt
- dmem_we  out  1  write strobe
- dmem_addr  out  OPERAND_WIDTH  word address {alu_result[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- out_valid  out  1  result available to writeback
- out_ready  in  1  writeback accepts the result
- out_data  out  OPERAND_WIDTH  extended load data, alu_result for non-memory ops, 0 for stores and errors
- out_err  out  2  mem_err_t: 00 NONE, 01 MISALIGNED, 10 BUS_TIMEOUT, 11 ILLEGAL

Behaviour:
- Reset, asynchronous: state=IDLE, timeout counter=0. Output values under reset:
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0.
  - out_valid=0, out_data=0, out_err=NONE.
  - in_ready=1.
- Reset mid-transaction drops dmem_req immediately; a dmem_rvalid or dmem_gnt arriving afterwards in IDLE is ignored.
- States and transitions:
  - IDLE: accept on in_valid&in_ready and latch all inputs.
    - Non-memory op -> RESP with out_data=alu_result.
    - Illegal size (load 011/11x, store 011/1xx, or read&write) -> RESP with err=ILLEGAL.
    - Misaligned (H with addr[0]=1, W with addr[1:0]!=0) -> RESP with err=MISALIGNED, no bus activity.
    - Otherwise -> REQ.
  - REQ: dmem_req=1, all bus outputs stable until gnt; counter increments each cycle.
    - Store on gnt -> RESP.
    - Load on gnt -> WAIT.
    - Load on gnt with rvalid in the same cycle -> RESP with the data captured.
  - WAIT: load with rvalid -> RESP with extended data captured.
  - Timeout: when the counter reaches TIMEOUT_CYCLES in REQ or WAIT -> RESP with err=BUS_TIMEOUT, dmem_req drops, and any later rvalid is ignored. The counter clears on entering REQ.
  - RESP: out_valid=1, result held stable until out_ready, then -> IDLE. out_valid is registered, never combinational from inputs.
- Latency (out_ready tied high, zero-wait bus):
  - dmem_req rises the cycle after accept.
  - Store out_valid follows one cycle after gnt.
  - Load out_valid follows one cycle after rvalid.
  - Error and non-memory op results appear the cycle after accept.
- Store lanes, with o=addr[1:0]:
  - SB: be=4'b0001<<o, wdata={4{wd[7:0]}}.
  - SH: be=o[1]?1100:0011, wdata={2{wd[15:0]}}.
  - SW: be=1111, wdata=wd.
  - Loads drive be=1111, we=0.
- Load extraction:
  - Byte = rdata[8*o+:8]; half = rdata[16*o[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- in_ready=(state==IDLE); a new instruction is never accepted in the same cycle a result leaves.

Decomposition:
- Common package:
  - mem_err_t enum.
  - load-size and store-size localparams (LB/LH/LW/LBU/LHU, SB/SH/SW).
  - lsu_state_t enum {IDLE, REQ, WAIT, RESP}.
- One natural sub-module: lsu_load_align, a combinational extract/extend of rdata given offset and size. Store lane generation stays inline.

Test Plan:
- SW addr 0x0000_0010, data 0xDEAD_BEEF, gnt after 2 cycles -> dmem_req high 3 cycles, be=1111, wdata=0xDEADBEEF, dmem_addr=0x10, out_valid one cycle after gnt, out_err=NONE.
- SB addr 0x13, data 0x0000_00A5 -> be=1000, wdata=0xA5A5A5A5.
- SH addr 0x12 -> be=1100, wdata replicated half.
- LB addr 0x21, rdata=0x0000_8000 -> out_data=0xFFFF_FF80. The same access as LBU -> out_data=0x0000_0080.
- LH addr 0x22, rdata 0x8001_0000 -> out_data 0xFFFF_8001.
- LW addr 0x06 -> out_err=MISALIGNED the cycle after accept, dmem_req never asserted. load_size=011 -> ILLEGAL.
- Load with gnt given but rvalid never returned, TIMEOUT_CYCLES=16 -> out_err=BUS_TIMEOUT at count 16. A late rvalid afterwards does not produce a second out_valid.
- out_ready held low 5 cycles in RESP -> out_data and out_err stable, in_ready=0. rst_n pulsed low during REQ -> dmem_req=0 asynchronously, state IDLE, no out_valid.
